// File: rtl/geva_mem_pkg.sv
// Shared types for the MEM-stage sequencer and data_mem_unit.
package geva_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned ESC_W  = 32;
    localparam int unsigned VEC_W  = 64;

    typedef enum logic [1:0] {
        LD_VEC = 2'b00,
        LD_ESC = 2'b01,
        ST_VEC = 2'b10,
        ST_ESC = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10
    } state_t;

    // Bit 1 of the opcode separates stores from loads.
    function automatic logic is_store(input mem_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request, memory-side and writeback signals of the MEM-stage sequencer.
interface mem_stage_ctrl_if
    import geva_mem_pkg::*;
#(
    parameter int unsigned RD_W = 5
);

    // EX/MEM request side
    logic              req_valid;
    mem_op_t           req_op;
    logic [ADDR_W-1:0] req_base_addr;
    logic [ESC_W-1:0]  req_data_esc;
    logic [VEC_W-1:0]  req_data_vec;
    logic [RD_W-1:0]   req_rd;
    logic              flush;
    logic              req_ready;
    logic              stall;

    // data_mem_unit side
    logic              mem_start;
    mem_op_t           mem_op;
    logic [ADDR_W-1:0] base_addr;
    logic [ESC_W-1:0]  data_in_esc;
    logic [VEC_W-1:0]  data_in_vec;
    logic              mem_rdy;
    logic [ESC_W-1:0]  data_out_esc;
    logic [VEC_W-1:0]  data_out_vec;

    // writeback side
    logic              wb_valid;
    logic              wb_is_vec;
    logic [RD_W-1:0]   wb_rd;
    logic [ESC_W-1:0]  wb_data_esc;
    logic [VEC_W-1:0]  wb_data_vec;
    logic              err_timeout;

    // The sequencer's view
    modport slave (
        input  req_valid, req_op, req_base_addr, req_data_esc, req_data_vec, req_rd, flush,
        input  mem_rdy, data_out_esc, data_out_vec,
        output req_ready, stall,
        output mem_start, mem_op, base_addr, data_in_esc, data_in_vec,
        output wb_valid, wb_is_vec, wb_rd, wb_data_esc, wb_data_vec, err_timeout
    );

    // The surrounding pipeline and memory's view
    modport master (
        output req_valid, req_op, req_base_addr, req_data_esc, req_data_vec, req_rd, flush,
        output mem_rdy, data_out_esc, data_out_vec,
        input  req_ready, stall,
        input  mem_start, mem_op, base_addr, data_in_esc, data_in_vec,
        input  wb_valid, wb_is_vec, wb_rd, wb_data_esc, wb_data_vec, err_timeout
    );

endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: holds one load/store, launches it on data_mem_unit,
// stalls until mem_rdy or timeout, and pulses load results to writeback.
module mem_stage_ctrl
    import geva_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned RD_W           = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_stage_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    mem_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ESC_W-1:0]  esc_q;
    logic [VEC_W-1:0]  vec_q;
    logic [RD_W-1:0]   rd_q;
    logic              squash_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_start_q;
    logic              wb_valid_q;
    logic              wb_is_vec_q;
    logic [RD_W-1:0]   wb_rd_q;
    logic [ESC_W-1:0]  wb_esc_q;
    logic [VEC_W-1:0]  wb_vec_q;
    logic              err_q;
    logic              accept;

    // Request acceptance: only in IDLE, and a flushed request is dropped.
    assign accept = (state_q == IDLE) && bus.req_valid && !bus.flush;

    // Handshake outputs; forced low while reset is held so every output reads 0.
    // The writeback cycle releases the pipeline even if a new request is taken then.
    assign bus.req_ready = rst_n && accept;
    assign bus.stall     = rst_n && ((state_q != IDLE) || (accept && !wb_valid_q));

    assign bus.mem_start   = mem_start_q;
    assign bus.mem_op      = op_q;
    assign bus.base_addr   = addr_q;
    assign bus.data_in_esc = esc_q;
    assign bus.data_in_vec = vec_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_is_vec   = wb_is_vec_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data_esc = wb_esc_q;
    assign bus.wb_data_vec = wb_vec_q;
    assign bus.err_timeout = err_q;

    // Sequencer FSM with holding registers, squash, timeout and writeback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= LD_VEC;
            addr_q      <= '0;
            esc_q       <= '0;
            vec_q       <= '0;
            rd_q        <= '0;
            squash_q    <= 1'b0;
            cnt_q       <= '0;
            mem_start_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_is_vec_q <= 1'b0;
            wb_rd_q     <= '0;
            wb_esc_q    <= '0;
            wb_vec_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_start_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q        <= bus.req_op;
                        addr_q      <= bus.req_base_addr;
                        esc_q       <= bus.req_data_esc;
                        vec_q       <= bus.req_data_vec;
                        rd_q        <= bus.req_rd;
                        mem_start_q <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                    if (bus.flush) squash_q <= 1'b1;
                end
                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.flush) squash_q <= 1'b1;
                    if (bus.mem_rdy) begin
                        state_q  <= IDLE;
                        squash_q <= 1'b0;
                        if (!is_store(op_q) && !squash_q && !bus.flush) begin
                            wb_valid_q  <= 1'b1;
                            wb_is_vec_q <= ~op_q[0];
                            wb_rd_q     <= rd_q;
                            wb_esc_q    <= bus.data_out_esc;
                            wb_vec_q    <= bus.data_out_vec;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= IDLE;
                        squash_q <= 1'b0;
                        err_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl with a behavioural data_mem_unit and a reference memory.
module tb_mem_stage_ctrl;
    import geva_mem_pkg::*;

    localparam int unsigned RD_W = 5;
    localparam int unsigned TMO  = 8;

    logic clk;
    logic rst_n;

    mem_stage_ctrl_if #(.RD_W(RD_W)) bus ();

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO), .RD_W(RD_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] bb_mem  [0:63];  // storage behind the memory model, written from DUT outputs
    logic [31:0] ref_mem [0:63];  // expected memory contents, written from issued requests
    int mem_lat  = 1;
    bit mem_dead = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Memory model: after mem_start, answer mem_lat cycles later with one mem_rdy pulse.
    initial begin
        int cnt;
        bit busy;
        int a;
        busy = 0;
        cnt  = 0;
        bus.mem_rdy      = 1'b0;
        bus.data_out_esc = '0;
        bus.data_out_vec = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                busy = 0;
                bus.mem_rdy = 1'b0;
                continue;
            end
            #1;
            bus.mem_rdy = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    a = int'(bus.base_addr[5:0]);
                    bus.data_out_esc = $urandom;
                    bus.data_out_vec = {$urandom, $urandom};
                    case (bus.mem_op)
                        ST_VEC: begin
                            bb_mem[a]            = bus.data_in_vec[31:0];
                            bb_mem[(a + 1) % 64] = bus.data_in_vec[63:32];
                        end
                        ST_ESC: bb_mem[a] = bus.data_in_esc;
                        LD_VEC: bus.data_out_vec = {bb_mem[(a + 1) % 64], bb_mem[a]};
                        default: bus.data_out_esc = bb_mem[a];
                    endcase
                    bus.mem_rdy = 1'b1;
                end
            end
            if (bus.mem_start && !busy && !mem_dead) begin
                busy = 1;
                cnt  = mem_lat;
            end
        end
    end

    // One full transaction; flush_cyc = 0 means no flush, else the cycle it is pulsed in.
    task automatic run_txn(input mem_op_t op, input logic [31:0] addr, input logic [31:0] de,
                           input logic [63:0] dv, input logic [RD_W-1:0] rd, input int lat,
                           input int flush_cyc, input string tag);
        bit          exp_wb;
        logic [63:0] exp_vec;
        logic [31:0] exp_esc;
        logic [63:0] prev_vec;
        logic [31:0] prev_esc;
        bit          done;
        int          k;
        int          a;
        a       = int'(addr[5:0]);
        exp_wb  = (op == LD_VEC || op == LD_ESC) && (flush_cyc == 0);
        exp_vec = {ref_mem[(a + 1) % 64], ref_mem[a]};
        exp_esc = ref_mem[a];
        if (op == ST_VEC) begin
            ref_mem[a]            = dv[31:0];
            ref_mem[(a + 1) % 64] = dv[63:32];
        end
        if (op == ST_ESC) ref_mem[a] = de;
        mem_lat = lat;

        @(posedge clk); #1;
        bus.req_valid     = 1'b1;
        bus.req_op        = op;
        bus.req_base_addr = addr;
        bus.req_data_esc  = de;
        bus.req_data_vec  = dv;
        bus.req_rd        = rd;
        @(negedge clk);
        prev_esc = bus.wb_data_esc;
        prev_vec = bus.wb_data_vec;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: req_ready=%b stall=%b expected 1 1", tag, bus.req_ready, bus.stall);
        end

        // Scramble request inputs so only the holding registers can drive the memory side.
        @(posedge clk); #1;
        bus.req_valid     = 1'b0;
        bus.req_op        = mem_op_t'($urandom_range(0, 3));
        bus.req_base_addr = $urandom;
        bus.req_data_esc  = $urandom;
        bus.req_data_vec  = {$urandom, $urandom};
        bus.req_rd        = RD_W'($urandom);
        bus.flush         = (flush_cyc == 1);
        @(negedge clk);
        checks++;
        if (bus.mem_start !== 1'b1 || bus.mem_op !== op || bus.base_addr !== addr || bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL %s start: mem_start=%b op=%0d addr=%h stall=%b expected 1 %0d %h 1",
                     tag, bus.mem_start, bus.mem_op, bus.base_addr, bus.stall, op, addr);
        end
        if (op == ST_VEC) begin
            checks++;
            if (bus.data_in_vec !== dv) begin
                failures++;
                $display("FAIL %s data_in_vec: got %h expected %h", tag, bus.data_in_vec, dv);
            end
        end
        if (op == ST_ESC) begin
            checks++;
            if (bus.data_in_esc !== de) begin
                failures++;
                $display("FAIL %s data_in_esc: got %h expected %h", tag, bus.data_in_esc, de);
            end
        end

        done = 0;
        k    = 2;
        while (!done && k < 200) begin
            @(posedge clk); #1;
            bus.flush = (k == flush_cyc);
            @(negedge clk);
            checks++;
            if (bus.mem_start !== 1'b0 || bus.base_addr !== addr || bus.mem_op !== op ||
                bus.stall !== 1'b1 || bus.wb_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s wait cyc%0d: mem_start=%b addr=%h op=%0d stall=%b wb_valid=%b expected 0 %h %0d 1 0",
                         tag, k, bus.mem_start, bus.base_addr, bus.mem_op, bus.stall, bus.wb_valid, addr, op);
            end
            done = bus.mem_rdy;
            k++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s no_mem_rdy: got none expected within budget", tag);
        end

        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wb_valid !== exp_wb) begin
            failures++;
            $display("FAIL %s wb_valid: got %b expected %b", tag, bus.wb_valid, exp_wb);
        end
        if (exp_wb) begin
            checks++;
            if (bus.wb_is_vec !== (op == LD_VEC) || bus.wb_rd !== rd || bus.stall !== 1'b0) begin
                failures++;
                $display("FAIL %s wb_fields: is_vec=%b rd=%0d stall=%b expected %b %0d 0",
                         tag, bus.wb_is_vec, bus.wb_rd, bus.stall, (op == LD_VEC), rd);
            end
            checks++;
            if (op == LD_VEC && bus.wb_data_vec !== exp_vec) begin
                failures++;
                $display("FAIL %s wb_data_vec: got %h expected %h", tag, bus.wb_data_vec, exp_vec);
            end else if (op == LD_ESC && bus.wb_data_esc !== exp_esc) begin
                failures++;
                $display("FAIL %s wb_data_esc: got %h expected %h", tag, bus.wb_data_esc, exp_esc);
            end
        end else begin
            checks++;
            if (bus.wb_data_esc !== prev_esc || bus.wb_data_vec !== prev_vec) begin
                failures++;
                $display("FAIL %s wb_hold: got %h %h expected %h %h",
                         tag, bus.wb_data_esc, bus.wb_data_vec, prev_esc, prev_vec);
            end
        end
        checks++;
        if (bus.mem_op !== op || bus.base_addr !== addr) begin
            failures++;
            $display("FAIL %s idle_hold: op=%0d addr=%h expected %0d %h", tag, bus.mem_op, bus.base_addr, op, addr);
        end
        if (op == ST_VEC || op == ST_ESC) begin
            checks++;
            if (bb_mem[a] !== ref_mem[a] || bb_mem[(a + 1) % 64] !== ref_mem[(a + 1) % 64]) begin
                failures++;
                $display("FAIL %s memory: got %h %h expected %h %h", tag, bb_mem[a], bb_mem[(a + 1) % 64],
                         ref_mem[a], ref_mem[(a + 1) % 64]);
            end
        end

        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s wb_pulse_width: got %b expected 0", tag, bus.wb_valid);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_op = LD_VEC; bus.req_base_addr = '0;
        bus.req_data_esc = '0; bus.req_data_vec = '0; bus.req_rd = '0; bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.req_valid = 1'b1;
        #1;
        checks++;
        if ({bus.req_ready, bus.stall, bus.mem_start, bus.mem_op, bus.base_addr, bus.data_in_esc,
             bus.data_in_vec, bus.wb_valid, bus.wb_is_vec, bus.wb_rd, bus.wb_data_esc,
             bus.wb_data_vec, bus.err_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b stall=%b start=%b op=%0d addr=%h wbv=%b err=%b expected all 0",
                     bus.req_ready, bus.stall, bus.mem_start, bus.mem_op, bus.base_addr, bus.wb_valid, bus.err_timeout);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_vec();
        run_txn(ST_VEC, 32'd0, 32'hdeadbeef, 64'h11111111ffffffff, 5'd0, 3, 0, "st_vec");
    endtask

    task automatic test_load_vec();
        run_txn(LD_VEC, 32'd0, 32'h0, 64'h0, 5'd3, 2, 0, "ld_vec");
    endtask

    task automatic test_scalar();
        run_txn(ST_ESC, 32'd1, 32'h22222222, 64'h0, 5'd0, 1, 0, "st_esc");
        run_txn(LD_ESC, 32'd1, 32'h0, 64'h0, 5'd7, 5, 0, "ld_esc");
    endtask

    task automatic test_flush();
        run_txn(LD_ESC, 32'd1, 32'h0, 64'h0, 5'd4, 5, 3, "flush_ld");
        run_txn(LD_VEC, 32'd0, 32'h0, 64'h0, 5'd9, 1, 0, "after_flush");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            mem_op_t op;
            int lat;
            int fc;
            op  = mem_op_t'($urandom_range(0, 3));
            lat = $urandom_range(1, 6);
            fc  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
            run_txn(op, 32'($urandom_range(0, 30)), $urandom, {$urandom, $urandom},
                    RD_W'($urandom), lat, fc, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_timeout();
        mem_dead = 1;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = LD_ESC; bus.req_base_addr = 32'd4; bus.req_rd = 5'd9;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL tmo_accept: req_ready=%b expected 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_start !== 1'b1) begin
            failures++;
            $display("FAIL tmo_start: mem_start=%b expected 1", bus.mem_start);
        end
        for (int c = 2; c <= int'(TMO) + 1; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (bus.err_timeout !== 1'b0 || bus.stall !== 1'b1) begin
                failures++;
                $display("FAIL tmo_wait cyc%0d: err=%b stall=%b expected 0 1", c, bus.err_timeout, bus.stall);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.err_timeout !== 1'b1 || bus.stall !== 1'b0 || bus.wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL tmo_fire: err=%b stall=%b wb_valid=%b expected 1 0 0",
                     bus.err_timeout, bus.stall, bus.wb_valid);
        end
        mem_dead = 0;
        run_txn(LD_ESC, 32'd1, 32'h0, 64'h0, 5'd2, 2, 0, "after_tmo");
        checks++;
        if (bus.err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL tmo_sticky: err=%b expected 1", bus.err_timeout);
        end
    endtask

    task automatic test_reset_in_wait();
        mem_lat = 10;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = LD_ESC; bus.req_base_addr = 32'd6; bus.req_rd = 5'd12;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.stall, bus.mem_start, bus.mem_op, bus.base_addr, bus.data_in_esc,
             bus.data_in_vec, bus.wb_valid, bus.wb_is_vec, bus.wb_rd, bus.wb_data_esc,
             bus.wb_data_vec, bus.err_timeout} !== '0) begin
            failures++;
            $display("FAIL async_reset: stall=%b start=%b addr=%h wbv=%b err=%b expected all 0",
                     bus.stall, bus.mem_start, bus.base_addr, bus.wb_valid, bus.err_timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(LD_ESC, 32'd1, 32'h0, 64'h0, 5'd7, 3, 0, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            bb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_store_vec();
        test_load_vec();
        test_scalar();
        test_flush();
        test_random();
        test_timeout();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Pipeline MEM-stage sequencer directly upstream of data_mem_unit.
- Accepts one scalar/vector load or store request from the EX/MEM register and drives data_mem_unit's mem_start/mem_op/base_addr/data_in_* with stable operands.
- Stalls the pipeline until mem_rdy, then hands load results to writeback with a one-cycle valid pulse.
- Also supports flush squashing and bounds the wait with a timeout.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT without mem_rdy before abort; must be >=2
RD_W, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  EX/MEM holds a memory request
req_op  in  2  mem_op_t: LD_VEC=00, LD_ESC=01, ST_VEC=10, ST_ESC=11
req_base_addr  in  32  base address
req_data_esc  in  32  scalar store data
req_data_vec  in  64  vector store data
req_rd  in  RD_W  load destination register
flush  in  1  squash current/incoming request
req_ready  out  1  request accepted this cycle
stall  out  1  freeze upstream pipeline
mem_start  out  1  start pulse to data_mem_unit
mem_op  out  2  to data_mem_unit
base_addr  out  32  to data_mem_unit
data_in_esc  out  32  to data_mem_unit
data_in_vec  out  64  to data_mem_unit
mem_rdy  in  1  from data_mem_unit, operation complete
data_out_esc  in  32  from data_mem_unit
data_out_vec  in  64  from data_mem_unit
wb_valid  out  1  load result valid, one-cycle pulse
wb_is_vec  out  1  1 = vector result
wb_rd  out  RD_W  destination register
wb_data_esc  out  32  scalar load data
wb_data_vec  out  64  vector load data
err_timeout  out  1  sticky timeout flag

Behaviour:
Reset:
- All outputs are 0; state is IDLE; the squash bit and timeout counter are 0.
- Assertion of rst_n mid-operation aborts immediately; the memory-side operation is abandoned.

States:
- IDLE:
  - req_ready = req_valid & ~flush.
  - On acceptance, latch op/addr/data/rd into holding registers and go to START.
  - req_valid & flush: the request is dropped and not accepted.
- START:
  - mem_start = 1 for exactly one cycle; go to WAIT.
  - mem_rdy is ignored in this state.
- WAIT:
  - Counter increments every cycle.
  - mem_rdy = 1: for a load that is not squashed, register data_out_* into wb_data_*, set wb_is_vec = ~op[0] and wb_rd = latched rd, and pulse wb_valid the next cycle. Then go to IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 without mem_rdy: set err_timeout, go to IDLE, no wb_valid.

Operand outputs:
- mem_op, base_addr and data_in_* come from the holding registers only.
- They are stable from START until the WAIT exit and are unchanged in IDLE.

Stall:
- stall = 1 in START and WAIT, and in IDLE while req_valid & ~flush (the accept cycle).
- stall = 0 on the cycle wb_valid is high.

Latency:
- Request accepted at cycle 0; mem_start at cycle 1.
- mem_rdy sampled at cycle k>=2 gives wb_valid at k+1.
- Minimum turnaround is one request per 3 cycles.

Flush:
- In START or WAIT, flush sets the squash bit. The operation still runs to mem_rdy, so a store is not cancelled, but wb_valid is suppressed.
- The squash bit clears on return to IDLE.

Other rules:
- Stores never assert wb_valid.
- wb_data_* hold their last value when wb_valid = 0.
- err_timeout is cleared only by rst_n.

Decomposition:
- Package geva_mem_pkg holds:
  - mem_op_t enum (LD_VEC, LD_ESC, ST_VEC, ST_ESC)
  - state_t enum (IDLE, START, WAIT)
  - helper function is_store(op) = op[1]
- data_mem_unit also imports this package.
- No sub-module. The timeout counter stays inline, width $clog2(TIMEOUT_CYCLES).

Test Plan:
1. ST_VEC, addr=0, data_in_vec=64'h11111111ffffffff; the data_mem_unit+data_mem_bb model returns mem_rdy -> mem_start is high exactly at cycle 1, stall is high until mem_rdy, wb_valid is never asserted, and the memory holds the words.
2. LD_VEC, addr=0, rd=3, after test 1 -> wb_valid pulses once with wb_is_vec=1, wb_rd=3, wb_data_vec=64'h11111111ffffffff.
3. ST_ESC, addr=1, data 32'h22222222, then LD_ESC, addr=1, rd=7 -> wb_data_esc=32'h22222222, wb_is_vec=0, and base_addr stays stable throughout WAIT.
4. LD_ESC accepted, flush pulsed during WAIT -> mem_rdy arrives, wb_valid stays 0, the FSM returns to IDLE, and the next request is accepted normally.
5. mem_rdy tied 0, TIMEOUT_CYCLES=8 -> err_timeout is set 8 cycles after START exit, state returns to IDLE, stall drops, err_timeout stays set until rst_n.
6. rst_n asserted while in WAIT -> all outputs are 0 immediately (asynchronously), and after release a new LD_ESC completes normally.
